// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg
//   Shared constants for the switch input stage.
//   DEFAULT_WIDTH          : number of board slide switches.
//   DEFAULT_STABLE_CYCLES  : hold time before a new switch vector is accepted
//                            (10 ms at a 100 MHz board clock).
//   MIN_STABLE_CYCLES      : smallest legal hold time.
package sw_debounce_pkg;

  localparam int DEFAULT_WIDTH         = 8;
  localparam int DEFAULT_STABLE_CYCLES = 1000000;
  localparam int MIN_STABLE_CYCLES     = 2;

endpackage : sw_debounce_pkg

// File: rtl/sw_debounce_sync_2ff.sv
// sync_2ff
//   Two-flop synchroniser for a vector of asynchronous inputs. No logic sits
//   between the flops so the first stage has a full cycle to resolve.
//   Ports:
//     clock : board clock
//     reset : synchronous, active-high; clears both stages
//     d     : asynchronous input levels (WIDTH bits)
//     q     : synchronised levels, two clocks behind d
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff

// File: rtl/sw_debounce.sv
// sw_debounce
//   Synchronises and debounces the board slide switches as one vector before
//   they feed the display datapath. A new vector is accepted only after the
//   synchronised value has held unchanged for STABLE_CYCLES clocks; any bit
//   change restarts the count for the whole vector.
//   Ports:
//     clock   : 100 MHz board clock
//     reset   : synchronous, active-high (btnC)
//     sw_in   : raw asynchronous switch levels
//     sw_out  : debounced, registered switch vector
//     changed : one-cycle pulse in the cycle sw_out takes a new value
//     busy    : registered; high while a candidate differs from sw_out or the
//               synchronised input differs from the candidate
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic             changed,
  output logic             busy
);

  localparam int              CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;

  sync_2ff #(
    .WIDTH(WIDTH)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (sw_in),
    .q    (sync2)
  );

  // Stability tracker. A fresh synchronised value becomes the candidate and
  // restarts the count; once the count saturates the candidate is committed.
  // The counter holds at CNT_MAX rather than wrapping, so a long-stable input
  // never re-triggers anything.
  always_ff @(posedge clock) begin
    if (reset) begin
      cand    <= '0;
      cnt     <= '0;
      sw_out  <= '0;
      changed <= 1'b0;
      busy    <= 1'b0;
    end else begin
      changed <= 1'b0;
      busy    <= (cand != sw_out) || (sync2 != cand);
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
        // Settling back to the current output completes the count silently.
        if (sw_out != cand) begin
          sw_out  <= cand;
          changed <= 1'b1;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce
//   Directed bench for sw_debounce with WIDTH=8, STABLE_CYCLES=4 (acceptance
//   7 clocks after an input step). Inputs change 1 time unit after a rising
//   edge; outputs are sampled at that same point, away from the edge.
module tb_sw_debounce;

  localparam int WIDTH   = 8;
  localparam int STABLE  = 4;
  localparam int LATENCY = STABLE + 3;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_out;
  logic             changed;
  logic             busy;

  int total;
  int bad;

  sw_debounce #(
    .WIDTH        (WIDTH),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .sw_in  (sw_in),
    .sw_out (sw_out),
    .changed(changed),
    .busy   (busy)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Bring the DUT to sw_out == 0 with sw_in == 0.
  task automatic clear_to_zero();
    sw_in = 8'h00;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Wait through an acceptance of val driven now; no comparisons here.
  task automatic settle_to(input logic [WIDTH-1:0] val);
    sw_in = val;
    for (int i = 0; i < LATENCY + 2; i++) tick();
  endtask

  task automatic test_reset();
    sw_in = 8'hA5;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (sw_out !== 8'h00 || changed !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d: sw_out=%h changed=%b busy=%b, want 00 0 0",
                 i, sw_out, changed, busy);
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= LATENCY + 1; i++) begin
      logic [WIDTH-1:0] exp_out;
      logic             exp_chg;
      tick();
      exp_out = (i >= LATENCY) ? 8'hA5 : 8'h00;
      exp_chg = (i == LATENCY);
      total++;
      if (sw_out !== exp_out || changed !== exp_chg) begin
        bad++;
        $display("FAIL reset_release cyc=%0d: sw_out=%h changed=%b, want %h %b",
                 i, sw_out, changed, exp_out, exp_chg);
      end
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_busy: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_step();
    int chg_count;
    clear_to_zero();
    settle_to(8'h00);
    chg_count = 0;
    sw_in = 8'h3C;
    for (int i = 1; i <= LATENCY + 2; i++) begin
      logic [WIDTH-1:0] exp_out;
      logic             exp_busy;
      tick();
      if (changed === 1'b1) chg_count++;
      exp_out = (i >= LATENCY) ? 8'h3C : 8'h00;
      // Registered busy: sync2 differs from cand at edge 3, clears one edge
      // after sw_out catches up.
      exp_busy = (i >= 3) && (i <= LATENCY);
      total++;
      if (sw_out !== exp_out || busy !== exp_busy) begin
        bad++;
        $display("FAIL step_3c cyc=%0d: sw_out=%h busy=%b, want %h %b",
                 i, sw_out, busy, exp_out, exp_busy);
      end
      if (i == LATENCY) begin
        total++;
        if (changed !== 1'b1) begin
          bad++;
          $display("FAIL step_3c_pulse: changed=%b, want 1", changed);
        end
      end
    end
    total++;
    if (chg_count != 1) begin
      bad++;
      $display("FAIL step_3c_pulse_count: got %0d pulses, want 1", chg_count);
    end
  endtask

  task automatic test_glitch_return();
    int chg_count;
    chg_count = 0;
    sw_in = 8'h3D;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (changed === 1'b1) chg_count++;
    end
    sw_in = 8'h3C;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (changed === 1'b1) chg_count++;
      total++;
      if (sw_out !== 8'h3C) begin
        bad++;
        $display("FAIL glitch_hold cyc=%0d: sw_out=%h, want 3c", i, sw_out);
      end
    end
    total++;
    if (chg_count != 0) begin
      bad++;
      $display("FAIL glitch_changed: got %0d pulses, want 0", chg_count);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL glitch_busy_end: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_bounce();
    int chg_count;
    chg_count = 0;
    // Ten 2-cycle segments: 01,00,01,...,00 -- never stable long enough.
    for (int seg = 0; seg < 10; seg++) begin
      sw_in = (seg % 2 == 0) ? 8'h01 : 8'h00;
      for (int c = 0; c < 2; c++) begin
        tick();
        if (changed === 1'b1) chg_count++;
        total++;
        if (sw_out !== 8'h3C) begin
          bad++;
          $display("FAIL bounce_hold seg=%0d: sw_out=%h, want 3c", seg, sw_out);
        end
      end
    end
    // Last toggle: settle at 01.
    sw_in = 8'h01;
    for (int i = 1; i <= LATENCY + 1; i++) begin
      logic [WIDTH-1:0] exp_out;
      tick();
      if (changed === 1'b1) chg_count++;
      exp_out = (i >= LATENCY) ? 8'h01 : 8'h3C;
      total++;
      if (sw_out !== exp_out) begin
        bad++;
        $display("FAIL bounce_settle cyc=%0d: sw_out=%h, want %h", i, sw_out, exp_out);
      end
    end
    total++;
    if (chg_count != 1) begin
      bad++;
      $display("FAIL bounce_pulse_count: got %0d pulses, want 1", chg_count);
    end
  endtask

  task automatic test_reset_mid_count();
    int chg_count;
    chg_count = 0;
    sw_in = 8'hFF;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    total++;
    if (sw_out !== 8'h00 || changed !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_clear: sw_out=%h changed=%b busy=%b, want 00 0 0",
               sw_out, changed, busy);
    end
    reset = 1'b0;
    for (int i = 1; i <= LATENCY + 2; i++) begin
      logic [WIDTH-1:0] exp_out;
      tick();
      if (changed === 1'b1) chg_count++;
      exp_out = (i >= LATENCY) ? 8'hFF : 8'h00;
      total++;
      if (sw_out !== exp_out) begin
        bad++;
        $display("FAIL midreset_reaccept cyc=%0d: sw_out=%h, want %h", i, sw_out, exp_out);
      end
    end
    total++;
    if (chg_count != 1) begin
      bad++;
      $display("FAIL midreset_pulse_count: got %0d pulses, want 1", chg_count);
    end
  endtask

  task automatic test_saturation();
    int errs;
    settle_to(8'h81);
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      total++;
      if (sw_out !== 8'h81 || changed !== 1'b0 || busy !== 1'b0) begin
        bad++;
        errs++;
        if (errs <= 5)
          $display("FAIL saturate cyc=%0d: sw_out=%h changed=%b busy=%b, want 81 0 0",
                   i, sw_out, changed, busy);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    sw_in = 8'h00;
    #1;
    test_reset();
    test_step();
    test_glitch_return();
    test_bounce();
    test_reset_mid_count();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sw_debounce
